// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Packet-level round-robin arbiter in front of an N:1 data mux. It picks one
//   valid requester and keeps that grant until the requester's last beat is
//   accepted. Accepted beats go into a single registered output stage that
//   supports backpressure.
//
// Parameters
//   N      number of requesters (>= 1)
//   WIDTH  data width per requester
//   SEL_W  derived select width: 1 when N <= 1, otherwise $clog2(N)
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   req_valid_i   per-requester beat valid
//   req_data_i    per-requester beat data (unpacked array of N words)
//   req_last_i    per-requester end-of-packet flag
//   req_ready_o   per-requester beat accept (valid & ready transfers a beat)
//   out_valid_o   registered output beat valid
//   out_data_o    registered output data
//   out_last_o    registered output end-of-packet flag
//   out_ready_i   downstream accept
//   grant_o       one-hot current grant; all zero when idle
//   sel_o         index of the granted requester; drives the data mux
//   pkt_cnt_o     count of completed packets leaving the output stage; wraps
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter  int N     = 4,
  parameter  int WIDTH = 32,
  localparam int SEL_W = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid_i,
  input  logic [WIDTH-1:0] req_data_i [N],
  input  logic [N-1:0]     req_last_i,
  output logic [N-1:0]     req_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     grant_o,
  output logic [SEL_W-1:0] sel_o,
  output logic [15:0]      pkt_cnt_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_grant;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [15:0]      r_pkt_cnt;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_pick;
  logic [WIDTH-1:0] w_mux_data;
  logic             w_beat_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_drain;
  logic [SEL_W-1:0] w_ptr_next;

  // Rotating priority search: first valid requester at or above r_ptr,
  // wrapping modulo N.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = SEL_W'((int'(r_ptr) + i) % N);
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // The shared N:1 datapath mux, steered by the registered select.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_mux_data = req_data_i[i];
      end
    end
  end

  // The output stage can take a beat when it is empty or draining this cycle.
  // Ready depends only on registered state and out_ready_i, never on valid.
  assign w_beat_ready = (r_state == ST_BUSY) && (out_ready_i || !r_out_valid);
  assign req_ready_o  = w_beat_ready ? r_grant : '0;
  assign w_accept     = w_beat_ready && |(req_valid_i & r_grant);
  assign w_last       = |(req_last_i & r_grant);
  assign w_drain      = r_out_valid && out_ready_i;
  assign w_ptr_next   = (r_sel == SEL_W'(N - 1)) ? '0 : r_sel + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_sel       <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= N'(1) << w_pick;
            r_sel   <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Grant is locked until the packet's last beat is accepted; a
          // requester that stalls mid-packet keeps the grant indefinitely.
          if (w_accept && w_last) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A load in the same cycle as a drain replaces the old beat.
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_last  <= w_last;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (w_drain && r_out_last) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  assign grant_o     = r_grant;
  assign sel_o       = r_sel;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign pkt_cnt_o   = r_pkt_cnt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed bench for mux_rr_arbiter (N=4, WIDTH=32). Each record holds one
//   cycle of stimulus, the req_ready_o expected before the clock edge, and the
//   registered outputs expected after it. Requester i presents data
//   {16'(i), dat}, so out_data_o identifies both the source and the beat.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid_i;
  logic [WIDTH-1:0] req_data_i [N];
  logic [N-1:0]     req_last_i;
  logic [N-1:0]     req_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_last_o;
  logic             out_ready_i;
  logic [N-1:0]     grant_o;
  logic [1:0]       sel_o;
  logic [15:0]      pkt_cnt_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .sel_o       (sel_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  typedef struct packed {
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] dat;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic [3:0]  e_grant;
    logic [1:0]  e_sel;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ol;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic r, input logic [3:0] va, input logic [3:0] la,
                               input logic [15:0] d, input logic o, input logic [3:0] erdy,
                               input logic [3:0] eg, input logic [1:0] es, input logic eov,
                               input logic [31:0] eod, input logic eol, input logic [15:0] ec);
    vec_t t;
    t = '{r, va, la, d, o, erdy, eg, es, eov, eod, eol, ec};
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Drive on the falling edge, check ready combinationally, then check the
  // registered outputs just after the rising edge.
  task automatic apply_vec(input vec_t t, input string tag);
    @(negedge clk);
    rst_n       = t.rst_n;
    req_valid_i = t.valid;
    req_last_i  = t.last;
    out_ready_i = t.ordy;
    for (int i = 0; i < N; i++) req_data_i[i] = {16'(i), t.dat};
    #1;
    check({tag, " req_ready"}, 32'(req_ready_o), 32'(t.e_rdy));
    @(posedge clk);
    #1;
    check({tag, " grant"},     32'(grant_o),     32'(t.e_grant));
    check({tag, " sel"},       32'(sel_o),       32'(t.e_sel));
    check({tag, " out_valid"}, 32'(out_valid_o), 32'(t.e_ov));
    check({tag, " out_data"},  out_data_o,       t.e_od);
    check({tag, " out_last"},  32'(out_last_o),  32'(t.e_ol));
    check({tag, " pkt_cnt"},   32'(pkt_cnt_o),   32'(t.e_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_end;
    int b_end;
    int r;
    int pr;
    logic [15:0] dat;

    // ---- Table A: single requester 2, 3-beat packet, then rr pointer = 3.
    tbl.push_back(mkv(1, 4'b0100, 4'b0000, 16'h00A0, 1, 4'b0000, 4'b0100, 2'd2, 0, 32'h0, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b0100, 4'b0000, 16'h00A0, 1, 4'b0100, 4'b0100, 2'd2, 1, 32'h0002_00A0, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b0100, 4'b0000, 16'h00B0, 1, 4'b0100, 4'b0100, 2'd2, 1, 32'h0002_00B0, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b0100, 4'b0100, 16'h00C0, 1, 4'b0100, 4'b0000, 2'd2, 1, 32'h0002_00C0, 1, 16'd0));
    tbl.push_back(mkv(1, 4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 2'd2, 0, 32'h0002_00C0, 1, 16'd1));
    tbl.push_back(mkv(1, 4'b1111, 4'b1111, 16'h00D0, 1, 4'b0000, 4'b1000, 2'd3, 0, 32'h0002_00C0, 1, 16'd1));
    tbl.push_back(mkv(1, 4'b1111, 4'b1111, 16'h00D0, 1, 4'b1000, 4'b0000, 2'd3, 1, 32'h0003_00D0, 1, 16'd1));
    a_end = tbl.size();

    // ---- Table B: reset, backpressure on req 0.
    tbl.push_back(mkv(0, 4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 2'd0, 0, 32'h0, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b0001, 4'b0000, 16'h0010, 1, 4'b0000, 4'b0001, 2'd0, 0, 32'h0, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b0001, 4'b0000, 16'h0010, 1, 4'b0001, 4'b0001, 2'd0, 1, 32'h0000_0010, 0, 16'd0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mkv(1, 4'b0001, 4'b0000, 16'h0011, 0, 4'b0000, 4'b0001, 2'd0, 1, 32'h0000_0010, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b0001, 4'b0000, 16'h0011, 1, 4'b0001, 4'b0001, 2'd0, 1, 32'h0000_0011, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b0001, 4'b0001, 16'h0012, 1, 4'b0001, 4'b0000, 2'd0, 1, 32'h0000_0012, 1, 16'd0));
    tbl.push_back(mkv(1, 4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 2'd0, 0, 32'h0000_0012, 1, 16'd1));
    // Packet lock: req 1 stalls 3 cycles while req 0 and req 3 wait.
    tbl.push_back(mkv(1, 4'b1011, 4'b0000, 16'h0020, 1, 4'b0000, 4'b0010, 2'd1, 0, 32'h0000_0012, 1, 16'd1));
    tbl.push_back(mkv(1, 4'b1011, 4'b0000, 16'h0020, 1, 4'b0010, 4'b0010, 2'd1, 1, 32'h0001_0020, 0, 16'd1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(1, 4'b1001, 4'b0000, 16'h0021, 1, 4'b0010, 4'b0010, 2'd1, 0, 32'h0001_0020, 0, 16'd1));
    tbl.push_back(mkv(1, 4'b1011, 4'b0010, 16'h0021, 1, 4'b0010, 4'b0000, 2'd1, 1, 32'h0001_0021, 1, 16'd1));
    tbl.push_back(mkv(1, 4'b1001, 4'b0000, 16'h0030, 1, 4'b0000, 4'b1000, 2'd3, 0, 32'h0001_0021, 1, 16'd2));
    // Reset after 2 of 4 beats of req 3, then fresh arbitration from req 0.
    tbl.push_back(mkv(1, 4'b1001, 4'b0000, 16'h0031, 1, 4'b1000, 4'b1000, 2'd3, 1, 32'h0003_0031, 0, 16'd2));
    tbl.push_back(mkv(1, 4'b1001, 4'b0000, 16'h0032, 1, 4'b1000, 4'b1000, 2'd3, 1, 32'h0003_0032, 0, 16'd2));
    tbl.push_back(mkv(0, 4'b1001, 4'b0000, 16'h0033, 1, 4'b1000, 4'b0000, 2'd0, 0, 32'h0, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b1001, 4'b0001, 16'h0040, 1, 4'b0000, 4'b0001, 2'd0, 0, 32'h0, 0, 16'd0));
    tbl.push_back(mkv(1, 4'b1001, 4'b0001, 16'h0040, 1, 4'b0001, 4'b0000, 2'd0, 1, 32'h0000_0040, 1, 16'd0));
    tbl.push_back(mkv(1, 4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 2'd0, 0, 32'h0000_0040, 1, 16'd1));
    b_end = tbl.size();

    // ---- Reset state.
    rst_n       = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    out_ready_i = 1'b1;
    for (int i = 0; i < N; i++) req_data_i[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready_o), 32'h0);
    check("reset grant",     32'(grant_o),     32'h0);
    check("reset sel",       32'(sel_o),       32'h0);
    check("reset out_valid", 32'(out_valid_o), 32'h0);
    check("reset out_data",  out_data_o,       32'h0);
    check("reset out_last",  32'(out_last_o),  32'h0);
    check("reset pkt_cnt",   32'(pkt_cnt_o),   32'h0);

    for (int i = 0; i < a_end; i++) apply_vec(tbl[i], $sformatf("tblA[%0d]", i));

    // ---- Fairness: all requesters send 1-beat packets continuously.
    apply_vec(mkv(0, 4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 2'd0, 0, 32'h0, 0, 16'd0), "rr reset");
    for (int k = 0; k < 8; k++) begin
      r   = k % 4;
      pr  = (k + 3) % 4;
      dat = 16'h00E0 + 16'(k);
      apply_vec(mkv(1, 4'b1111, 4'b1111, dat, 1, 4'b0000, 4'(1 << r), 2'(r), 0,
                    (k == 0) ? 32'h0 : {16'(pr), dat - 16'd1}, (k != 0), 16'(k)),
                $sformatf("rr%0d arb", k));
      apply_vec(mkv(1, 4'b1111, 4'b1111, dat, 1, 4'(1 << r), 4'b0000, 2'(r), 1,
                    {16'(r), dat}, 1, 16'(k)),
                $sformatf("rr%0d beat", k));
    end
    apply_vec(mkv(1, 4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 2'd3, 0, 32'h0003_00E7, 1, 16'd8), "rr done");

    for (int i = a_end; i < b_end; i++) apply_vec(tbl[i], $sformatf("tblB[%0d]", i - a_end));

    // ---- Counter wrap: preset to 0xFFFF, then one packet from req 2.
    @(negedge clk);
    force dut.r_pkt_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_pkt_cnt;
    #1;
    check("wrap preset pkt_cnt", 32'(pkt_cnt_o), 32'h0000_FFFF);
    apply_vec(mkv(1, 4'b0100, 4'b0100, 16'h0050, 1, 4'b0000, 4'b0100, 2'd2, 0, 32'h0000_0040, 1, 16'hFFFF), "wrap arb");
    apply_vec(mkv(1, 4'b0100, 4'b0100, 16'h0050, 1, 4'b0100, 4'b0000, 2'd2, 1, 32'h0002_0050, 1, 16'hFFFF), "wrap beat");
    apply_vec(mkv(1, 4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 2'd2, 0, 32'h0002_0050, 1, 16'h0000), "wrap out");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
